hash_request_frontend: RTL and testbench
========================================

HASH_REQUEST_FRONTEND -- requirements
Module: hash_request_frontend

Interface
REQ-001 Parameter KEY_WIDTH, default 2: key width in bits.
REQ-002 Parameter DATA_WIDTH, default 32: data width in bits.
REQ-003 Parameter LOOKUP_LATENCY, default 2, legal range 0..15: enabled cycles between key presentation and valid table read-out at the controller.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low; reset is asserted when low and sampled on clk.
REQ-006 clk_en  in  1  global clock enable; when low, all state holds.
REQ-007 req_valid_i / req_ready_o  in / out  1 / 1  host request handshake.
REQ-008 req_op_i  in  2  operation: 00 nothing, 01 read, 10 write, 11 delete.
REQ-009 req_key_i / req_data_i  in  KEY_WIDTH / DATA_WIDTH  request key and write data.
REQ-010 resp_valid_o / resp_ready_i  out / in  1 / 1  host response handshake.
REQ-011 resp_op_o  out  2  echo of the accepted opcode.
REQ-012 resp_status_o  out  3  000 OK, 001 NOT_FOUND, 010 NO_DEL_TARGET, 011 NO_SPACE, 100 KEY_PRESENT, 111 PROTOCOL_ERR.
REQ-013 resp_data_o  out  DATA_WIDTH  read result; 0 unless status OK on a read.
REQ-014 key_o / data_o  out  KEY_WIDTH / DATA_WIDTH  key and data driven to the hash units and the controller.
REQ-015 delete_write_read_o  out  2  opcode driven to the controller.
REQ-016 read_data_i, valid_i, no_deletion_target_i, no_write_space_i, no_element_found_i, key_already_present_i  in  DATA_WIDTH, 1, 1, 1, 1, 1  controller results.
REQ-017 err_count_o  out  16  saturating count of non-OK responses.

Function
REQ-018 FSM states: IDLE, LOOKUP, EXECUTE, RESPOND; a transition occurs only on a cycle with clk_en=1.
REQ-019 req_ready_o SHALL be 1 only in IDLE; a request is accepted on an edge with req_valid_i=1, req_ready_o=1 and clk_en=1.
REQ-020 On acceptance, the block SHALL register req_op_i, req_key_i and req_data_i; key_o and data_o SHALL output the registered values, which remain stable until the next acceptance.
REQ-021 Opcode 00 accepted: go directly to RESPOND with status OK, data 0; no controller operation is driven.
REQ-022 Other opcodes: IDLE->LOOKUP; a 4-bit counter loads LOOKUP_LATENCY; LOOKUP decrements per enabled cycle; at 0 go to EXECUTE; LOOKUP_LATENCY=0 goes IDLE->EXECUTE directly.
REQ-023 delete_write_read_o SHALL equal the registered opcode only in EXECUTE and 00 in all other states, so no table write can occur during LOOKUP.
REQ-024 EXECUTE lasts exactly one enabled cycle; on that edge the block captures status and data, then moves to RESPOND.
REQ-025 Status priority in EXECUTE: valid_i=0 -> PROTOCOL_ERR; else key_already_present_i -> KEY_PRESENT; else no_write_space_i -> NO_SPACE; else no_deletion_target_i -> NO_DEL_TARGET; else no_element_found_i -> NOT_FOUND; else OK.
REQ-026 resp_data_o captures read_data_i only when the opcode is read and status is OK; otherwise it is 0.
REQ-027 In RESPOND, resp_valid_o=1 and response fields are stable; on resp_ready_i=1 with clk_en=1, the FSM returns to IDLE.
REQ-028 Minimum latency from acceptance edge T to resp_valid_o high is LOOKUP_LATENCY+2 cycles; throughput is one operation per LOOKUP_LATENCY+3 cycles with resp_ready_i held high.
REQ-029 err_count_o increments by 1 on each edge that enters RESPOND with a non-OK status, and saturates at 0xFFFF.
REQ-030 With clk_en=0, the FSM, counters, registers and all outputs SHALL hold; in EXECUTE, the opcode stays driven.

Reset
REQ-031 reset low on an edge: FSM->IDLE, lookup counter 0, err_count_o 0, registered op/key/data 0, resp_valid_o 0, resp_status_o 000, resp_data_o 0, delete_write_read_o 00, req_ready_o 1 on the following cycle.
REQ-032 Reset overrides clk_en and aborts any in-flight operation, including EXECUTE; the pending response is discarded.

Verification
REQ-033 LOOKUP_LATENCY=2; write key 2'b01, data 0xDEADBEEF; controller flags 0, valid_i=1 -> delete_write_read_o=10 for exactly one cycle at T+3; resp_valid_o at T+4 with status 000, data 0.
REQ-034 Read key 2'b01; read_data_i=0xDEADBEEF in EXECUTE -> status 000, resp_data_o=0xDEADBEEF; write of the same key with key_already_present_i=1 and no_write_space_i=1 -> status 100, err_count_o=1.
REQ-035 Read with no_element_found_i=1 -> status 001, data 0; delete with no_deletion_target_i=1 -> status 010; EXECUTE with valid_i=0 -> status 111.
REQ-036 Hold resp_ready_i=0 for 5 cycles while issuing a second req_valid_i -> req_ready_o stays 0 and response fields stay stable; second request is accepted only after the response handshake.
REQ-037 Toggle clk_en low during LOOKUP and EXECUTE -> latency extends by the number of disabled cycles, and exactly one EXECUTE edge occurs; LOOKUP_LATENCY=0 -> response at T+2.
REQ-038 Assert reset low during EXECUTE -> next cycle delete_write_read_o=00, resp_valid_o=0, err_count_o=0; force 65537 errors -> err_count_o=0xFFFF.

Source files
------------

// File: rtl/hash_request_frontend_if.sv
// Host request/response channel between a requester and hash_request_frontend.
interface hash_req_if #(
  parameter int KEY_WIDTH  = 2,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [KEY_WIDTH-1:0]  req_key_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [1:0]            resp_op_o;
  logic [2:0]            resp_status_o;
  logic [DATA_WIDTH-1:0] resp_data_o;

  modport master (
    output req_valid_i, req_op_i, req_key_i, req_data_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_op_o, resp_status_o, resp_data_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_key_i, req_data_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_op_o, resp_status_o, resp_data_o
  );
endinterface

// File: rtl/hash_request_frontend.sv
// Request frontend for a hash table controller: accepts one host operation,
// waits out the table lookup latency, drives the op for one cycle, returns status.
//
// state   | meaning
// IDLE    | ready for a host request
// LOOKUP  | key presented, counting down table read latency
// EXECUTE | opcode driven to controller, result captured on this edge
// RESPOND | response held until host accepts it
module hash_request_frontend #(
  parameter int KEY_WIDTH      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int LOOKUP_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  hash_req_if.slave             host,
  output logic [KEY_WIDTH-1:0]  key_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            delete_write_read_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  input  logic                  valid_i,
  input  logic                  no_deletion_target_i,
  input  logic                  no_write_space_i,
  input  logic                  no_element_found_i,
  input  logic                  key_already_present_i,
  output logic [15:0]           err_count_o
);

  typedef enum logic [1:0] {IDLE, LOOKUP, EXECUTE, RESPOND} state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;

  localparam logic [2:0] ST_OK          = 3'b000;
  localparam logic [2:0] ST_NOT_FOUND   = 3'b001;
  localparam logic [2:0] ST_NO_DEL      = 3'b010;
  localparam logic [2:0] ST_NO_SPACE    = 3'b011;
  localparam logic [2:0] ST_KEY_PRESENT = 3'b100;
  localparam logic [2:0] ST_PROTO_ERR   = 3'b111;

  localparam logic [3:0] LAT = 4'(LOOKUP_LATENCY);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            status_q, status_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [15:0]           err_q, err_d;
  logic [2:0]            exec_status;

  always_comb begin
    exec_status = ST_OK;
    if (!valid_i)                   exec_status = ST_PROTO_ERR;
    else if (key_already_present_i) exec_status = ST_KEY_PRESENT;
    else if (no_write_space_i)      exec_status = ST_NO_SPACE;
    else if (no_deletion_target_i)  exec_status = ST_NO_DEL;
    else if (no_element_found_i)    exec_status = ST_NOT_FOUND;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    key_d    = key_q;
    data_d   = data_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (host.req_valid_i) begin
            op_d   = host.req_op_i;
            key_d  = host.req_key_i;
            data_d = host.req_data_i;
            if (host.req_op_i == OP_NOP) begin
              state_d  = RESPOND;
              status_d = ST_OK;
              rdata_d  = '0;
            end else if (LAT == 4'd0) begin
              state_d = EXECUTE;
            end else begin
              state_d = LOOKUP;
              cnt_d   = LAT;
            end
          end
        end
        LOOKUP: begin
          // Leave on the edge where the count reaches zero so LOOKUP spans LAT cycles.
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = EXECUTE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        EXECUTE: begin
          status_d = exec_status;
          rdata_d  = (op_q == OP_READ && exec_status == ST_OK) ? read_data_i : '0;
          if (exec_status != ST_OK && err_q != 16'hFFFF) err_d = err_q + 16'd1;
          state_d = RESPOND;
        end
        RESPOND: begin
          if (host.resp_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      op_q     <= 2'b00;
      key_q    <= '0;
      data_q   <= '0;
      status_q <= ST_OK;
      rdata_q  <= '0;
      err_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      key_q    <= key_d;
      data_q   <= data_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign host.req_ready_o   = (state_q == IDLE);
  assign host.resp_valid_o  = (state_q == RESPOND);
  assign host.resp_op_o     = op_q;
  assign host.resp_status_o = status_q;
  assign host.resp_data_o   = rdata_q;
  assign key_o              = key_q;
  assign data_o             = data_q;
  assign delete_write_read_o = (state_q == EXECUTE) ? op_q : 2'b00;
  assign err_count_o        = err_q;

endmodule

// File: tb/tb_hash_request_frontend.sv
// Directed bench for hash_request_frontend (LOOKUP_LATENCY 2, plus a latency-0 instance).
module tb_hash_request_frontend;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clk_en;
  logic [31:0] read_data;
  logic        valid, no_del, no_space, no_elem, key_present;
  logic [1:0]  key_o, key0_o;
  logic [31:0] data_o, data0_o;
  logic [1:0]  dwr, dwr0;
  logic [15:0] err, err0;

  hash_req_if #(.KEY_WIDTH(2), .DATA_WIDTH(32)) hif ();
  hash_req_if #(.KEY_WIDTH(2), .DATA_WIDTH(32)) hif0 ();

  hash_request_frontend #(.KEY_WIDTH(2), .DATA_WIDTH(32), .LOOKUP_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .host(hif),
    .key_o(key_o), .data_o(data_o), .delete_write_read_o(dwr),
    .read_data_i(read_data), .valid_i(valid), .no_deletion_target_i(no_del),
    .no_write_space_i(no_space), .no_element_found_i(no_elem),
    .key_already_present_i(key_present), .err_count_o(err));

  hash_request_frontend #(.KEY_WIDTH(2), .DATA_WIDTH(32), .LOOKUP_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .host(hif0),
    .key_o(key0_o), .data_o(data0_o), .delete_write_read_o(dwr0),
    .read_data_i(read_data), .valid_i(valid), .no_deletion_target_i(no_del),
    .no_write_space_i(no_space), .no_element_found_i(no_elem),
    .key_already_present_i(key_present), .err_count_o(err0));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int exec_hi = 0;
  int last_exec_cyc = 0;
  logic [1:0] last_dwr = 2'b00;
  logic [15:0] exp_err = 16'd0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dwr != 2'b00) begin
      exec_hi++;
      last_dwr = dwr;
      last_exec_cyc = cyc;
    end
  end

  task automatic set_ctrl(input logic v, input logic kp, input logic ns, input logic nd,
                          input logic ne, input logic [31:0] rd);
    valid = v; key_present = kp; no_space = ns; no_del = nd; no_elem = ne; read_data = rd;
  endtask

  // Present a request and return at the first falling edge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [1:0] key, input logic [31:0] data);
    int n = 0;
    hif.req_valid_i = 1'b1; hif.req_op_i = op; hif.req_key_i = key; hif.req_data_i = data;
    while (!hif.req_ready_o && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (hif.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL issue_timeout req_ready_o=%b required 1", hif.req_ready_o);
    end
    @(posedge clk); @(negedge clk);
    acc_cyc = cyc;
    hif.req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(output int rel);
    int n = 0;
    while (!hif.resp_valid_o && n < 60) begin @(negedge clk); n++; end
    rel = hif.resp_valid_o ? (cyc - acc_cyc + 1) : -1;
  endtask

  task automatic consume();
    hif.resp_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    hif.resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (hif.req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", hif.req_ready_o); end
    checks++; if (hif.resp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", hif.resp_valid_o); end
    checks++; if (hif.resp_status_o !== 3'b000) begin errors++; $display("FAIL rst_status got %b exp 000", hif.resp_status_o); end
    checks++; if (hif.resp_data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", hif.resp_data_o); end
    checks++; if (dwr !== 2'b00) begin errors++; $display("FAIL rst_dwr got %b exp 00", dwr); end
    checks++; if (err !== 16'h0) begin errors++; $display("FAIL rst_err got %h exp 0", err); end
    checks++; if ({key_o, data_o} !== 34'h0) begin errors++; $display("FAIL rst_keydata got %h exp 0", {key_o, data_o}); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int rel; int e0;
    set_ctrl(1, 0, 0, 0, 0, 32'h0);
    e0 = exec_hi;
    issue(2'b10, 2'b01, 32'hDEADBEEF);
    wait_resp(rel);
    checks++; if (rel !== 4) begin errors++; $display("FAIL wr_latency got %0d exp 4", rel); end
    checks++; if (exec_hi - e0 !== 1) begin errors++; $display("FAIL wr_exec_cycles got %0d exp 1", exec_hi - e0); end
    checks++; if (last_exec_cyc - acc_cyc + 1 !== 3) begin errors++; $display("FAIL wr_exec_at got %0d exp 3", last_exec_cyc - acc_cyc + 1); end
    checks++; if (last_dwr !== 2'b10) begin errors++; $display("FAIL wr_dwr got %b exp 10", last_dwr); end
    checks++; if (hif.resp_status_o !== 3'b000) begin errors++; $display("FAIL wr_status got %b exp 000", hif.resp_status_o); end
    checks++; if (hif.resp_data_o !== 32'h0) begin errors++; $display("FAIL wr_data got %h exp 0", hif.resp_data_o); end
    checks++; if (hif.resp_op_o !== 2'b10) begin errors++; $display("FAIL wr_op got %b exp 10", hif.resp_op_o); end
    checks++; if ({key_o, data_o} !== {2'b01, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_keydata got %h exp 1deadbeef", {key_o, data_o}); end
    consume();
    checks++; if (hif.resp_valid_o !== 1'b0 || hif.req_ready_o !== 1'b1) begin errors++; $display("FAIL wr_handshake got valid=%b ready=%b exp 0/1", hif.resp_valid_o, hif.req_ready_o); end
  endtask

  // One error-or-OK operation with expected status/data/counter, consumed at the end.
  task automatic test_status_cases();
    int rel;
    logic [1:0]  ops  [6] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
    logic [5:0]  ctl  [6] = '{6'b100000, 6'b111000, 6'b101000, 6'b100001, 6'b100010, 6'b010000};
    logic [2:0]  st   [6] = '{3'b000, 3'b100, 3'b011, 3'b001, 3'b010, 3'b111};
    logic [31:0] dat  [6] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      // ctl = {valid, key_present, no_space, unused, no_del, no_elem}
      set_ctrl(ctl[i][5], ctl[i][4], ctl[i][3], ctl[i][1], ctl[i][0], 32'hDEADBEEF);
      issue(ops[i], 2'b01, 32'h1234_0000 + 32'(i));
      wait_resp(rel);
      if (st[i] != 3'b000) exp_err = exp_err + 16'd1;
      checks++; if (rel !== 4) begin errors++; $display("FAIL case%0d_latency got %0d exp 4", i, rel); end
      checks++; if (hif.resp_status_o !== st[i]) begin errors++; $display("FAIL case%0d_status got %b exp %b", i, hif.resp_status_o, st[i]); end
      checks++; if (hif.resp_data_o !== dat[i]) begin errors++; $display("FAIL case%0d_data got %h exp %h", i, hif.resp_data_o, dat[i]); end
      checks++; if (last_dwr !== ops[i]) begin errors++; $display("FAIL case%0d_dwr got %b exp %b", i, last_dwr, ops[i]); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL case%0d_err got %0d exp %0d", i, err, exp_err); end
      consume();
    end
  endtask

  task automatic test_nop();
    int rel; int e0;
    set_ctrl(0, 1, 1, 1, 1, 32'hFFFFFFFF);
    e0 = exec_hi;
    issue(2'b00, 2'b11, 32'hCAFE0000);
    wait_resp(rel);
    checks++; if (rel !== 1) begin errors++; $display("FAIL nop_latency got %0d exp 1", rel); end
    checks++; if (exec_hi !== e0) begin errors++; $display("FAIL nop_exec got %0d exp %0d", exec_hi, e0); end
    checks++; if ({hif.resp_op_o, hif.resp_status_o, hif.resp_data_o} !== 37'h0) begin errors++; $display("FAIL nop_resp got %h exp 0", {hif.resp_op_o, hif.resp_status_o, hif.resp_data_o}); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL nop_err got %0d exp %0d", err, exp_err); end
    consume();
  endtask

  task automatic test_backpressure();
    int rel; int bad = 0;
    set_ctrl(1, 0, 0, 0, 0, 32'h0BADF00D);
    issue(2'b01, 2'b10, 32'h0);
    wait_resp(rel);
    hif.req_valid_i = 1'b1; hif.req_op_i = 2'b10; hif.req_key_i = 2'b11; hif.req_data_i = 32'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (hif.req_ready_o !== 1'b0 || hif.resp_valid_o !== 1'b1 || hif.resp_status_o !== 3'b000 ||
          hif.resp_data_o !== 32'h0BADF00D || key_o !== 2'b10) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold bad_cycles got %0d exp 0", bad); end
    consume();
    set_ctrl(1, 0, 0, 0, 0, 32'h0);
    issue(2'b10, 2'b11, 32'h55);
    wait_resp(rel);
    checks++; if (rel !== 4 || key_o !== 2'b11 || last_dwr !== 2'b10) begin errors++; $display("FAIL bp_second got rel=%0d key=%b dwr=%b exp 4/11/10", rel, key_o, last_dwr); end
    consume();
  endtask

  task automatic test_back_to_back();
    int a1; int rel;
    set_ctrl(1, 0, 0, 0, 0, 32'h0);
    hif.resp_ready_i = 1'b1;
    issue(2'b10, 2'b10, 32'h1);
    a1 = acc_cyc;
    issue(2'b10, 2'b11, 32'h2);
    checks++; if (acc_cyc - a1 !== 5) begin errors++; $display("FAIL b2b_spacing got %0d exp 5", acc_cyc - a1); end
    wait_resp(rel);
    checks++; if (rel !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", rel); end
    @(negedge clk);
    hif.resp_ready_i = 1'b0;
    checks++; if (hif.resp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", hif.resp_valid_o); end
  endtask

  task automatic test_clk_en();
    int rel; int e0; int n = 0;
    set_ctrl(1, 0, 0, 0, 1, 32'h0);
    e0 = exec_hi;
    issue(2'b01, 2'b01, 32'h0);
    clk_en = 1'b0;
    repeat (2) @(negedge clk);
    clk_en = 1'b1;
    while (dwr == 2'b00 && n < 20) begin @(negedge clk); n++; end
    clk_en = 1'b0;
    @(negedge clk);
    checks++; if (dwr !== 2'b01) begin errors++; $display("FAIL ce_exec_hold got %b exp 01", dwr); end
    clk_en = 1'b1;
    wait_resp(rel);
    exp_err = exp_err + 16'd1;
    checks++; if (rel !== 7) begin errors++; $display("FAIL ce_latency got %0d exp 7", rel); end
    checks++; if (exec_hi - e0 !== 2) begin errors++; $display("FAIL ce_exec_cycles got %0d exp 2", exec_hi - e0); end
    checks++; if (err !== exp_err || hif.resp_status_o !== 3'b001) begin errors++; $display("FAIL ce_result got err=%0d st=%b exp %0d/001", err, hif.resp_status_o, exp_err); end
    consume();
  endtask

  task automatic test_latency_zero();
    set_ctrl(1, 0, 0, 0, 0, 32'h0);
    hif0.req_valid_i = 1'b1; hif0.req_op_i = 2'b10; hif0.req_key_i = 2'b01; hif0.req_data_i = 32'h77;
    @(posedge clk); @(negedge clk);
    hif0.req_valid_i = 1'b0;
    checks++; if (dwr0 !== 2'b10 || hif0.resp_valid_o !== 1'b0) begin errors++; $display("FAIL l0_exec got dwr=%b valid=%b exp 10/0", dwr0, hif0.resp_valid_o); end
    @(negedge clk);
    checks++; if (hif0.resp_valid_o !== 1'b1 || hif0.resp_status_o !== 3'b000 || dwr0 !== 2'b00) begin errors++; $display("FAIL l0_resp got valid=%b st=%b dwr=%b exp 1/000/00", hif0.resp_valid_o, hif0.resp_status_o, dwr0); end
    hif0.resp_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    hif0.resp_ready_i = 1'b0;
  endtask

  task automatic test_reset_exec();
    int n = 0;
    set_ctrl(0, 0, 0, 0, 0, 32'h0);
    issue(2'b10, 2'b10, 32'h99);
    while (dwr == 2'b00 && n < 20) begin @(negedge clk); n++; end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (dwr !== 2'b00 || hif.resp_valid_o !== 1'b0 || err !== 16'h0) begin errors++; $display("FAIL rx_abort got dwr=%b valid=%b err=%0d exp 00/0/0", dwr, hif.resp_valid_o, err); end
    checks++; if (hif.req_ready_o !== 1'b1 || key_o !== 2'b00) begin errors++; $display("FAIL rx_idle got ready=%b key=%b exp 1/00", hif.req_ready_o, key_o); end
    reset = 1'b1;
    exp_err = 16'h0;
    repeat (2) @(negedge clk);
    checks++; if (hif.resp_valid_o !== 1'b0) begin errors++; $display("FAIL rx_discard got %b exp 0", hif.resp_valid_o); end
  endtask

  // Preloading the counter near full stands in for tens of thousands of error ops.
  task automatic test_saturation();
    int rel;
    logic [15:0] exp_sat [3] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
    force dut.err_q = 16'hFFFD;
    repeat (2) @(negedge clk);
    release dut.err_q;
    @(negedge clk);
    checks++; if (err !== 16'hFFFD) begin errors++; $display("FAIL sat_preload got %h exp fffd", err); end
    set_ctrl(0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      issue(2'b01, 2'b00, 32'h0);
      wait_resp(rel);
      checks++; if (err !== exp_sat[i]) begin errors++; $display("FAIL sat_%0d got %h exp %h", i, err, exp_sat[i]); end
      consume();
    end
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b1;
    set_ctrl(1, 0, 0, 0, 0, 32'h0);
    hif.req_valid_i = 1'b0; hif.req_op_i = 2'b00; hif.req_key_i = 2'b00; hif.req_data_i = 32'h0; hif.resp_ready_i = 1'b0;
    hif0.req_valid_i = 1'b0; hif0.req_op_i = 2'b00; hif0.req_key_i = 2'b00; hif0.req_data_i = 32'h0; hif0.resp_ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_status_cases();
    test_nop();
    test_backpressure();
    test_back_to_back();
    test_clk_en();
    test_latency_zero();
    test_reset_exec();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
